// File: rtl/delay_mem_arbiter.sv
// delay_mem_arbiter: round-robin arbiter serialising per-port write/read requests
// onto one shared synchronous delay-line RAM.
module delay_mem_arbiter #(
    parameter int data_width  = 16,
    parameter int n_ports     = 4,
    parameter int memory_size = 4096,
    localparam int addr_width = $clog2(memory_size),
    localparam int port_width = $clog2(n_ports)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [n_ports-1:0]               wr_req,
    input  logic [n_ports*addr_width-1:0]    wr_addr,
    input  logic [n_ports*data_width-1:0]    wr_data,
    input  logic [n_ports-1:0]               rd_req,
    input  logic [n_ports*addr_width-1:0]    rd_addr,
    output logic [n_ports-1:0]               wr_ack,
    output logic [n_ports-1:0]               rd_valid,
    output logic [data_width-1:0]            rd_data,
    output logic [port_width-1:0]            grant_port,
    output logic                             busy,
    output logic                             invalid
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [addr_width:0] MEM_LIM = memory_size[addr_width:0];

    logic [2:0]            r_state;
    logic [port_width-1:0] r_ptr;
    logic [port_width-1:0] r_port;
    logic [addr_width-1:0] r_addr;
    logic [data_width-1:0] r_data;
    logic                  r_op;
    logic [data_width-1:0] r_ram_q;
    logic [data_width-1:0] r_mem [memory_size];
    logic [n_ports-1:0]    w_req_any;
    logic                  w_found;
    logic [port_width-1:0] w_sel;
    logic                  w_in_range;

    assign w_req_any  = wr_req | rd_req;
    assign w_found    = |w_req_any;
    assign w_in_range = {1'b0, r_addr} < MEM_LIM;
    assign busy       = r_state != S_IDLE;

    // Descending scan so the nearest port after the pointer is the last assignment.
    always_comb begin
        w_sel = '0;
        for (int k = n_ports; k >= 1; k--)
            if (w_req_any[port_width'((int'(r_ptr) + k) % n_ports)])
                w_sel = port_width'((int'(r_ptr) + k) % n_ports);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= port_width'(n_ports - 1);
            r_port     <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_op       <= 1'b0;
            wr_ack     <= '0;
            rd_valid   <= '0;
            rd_data    <= '0;
            grant_port <= '0;
            invalid    <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_port     <= w_sel;
                    r_ptr      <= w_sel;
                    grant_port <= w_sel;
                    r_op       <= wr_req[w_sel];
                    r_addr     <= wr_req[w_sel] ? wr_addr[int'(w_sel)*addr_width +: addr_width]
                                                : rd_addr[int'(w_sel)*addr_width +: addr_width];
                    r_data     <= wr_data[int'(w_sel)*data_width +: data_width];
                    r_state    <= wr_req[w_sel] ? S_WR : S_RD;
                end
                S_WR: begin
                    wr_ack[r_port] <= 1'b1;
                    invalid        <= !w_in_range;
                    r_state        <= S_DONE;
                end
                S_RD: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    rd_data          <= w_in_range ? r_ram_q : '0;
                    rd_valid[r_port] <= 1'b1;
                    invalid          <= !w_in_range;
                    r_state          <= S_DONE;
                end
                default: begin
                    wr_ack   <= '0;
                    rd_valid <= '0;
                    invalid  <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // RAM contents survive reset; out-of-range accesses are masked above.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (r_state == S_WR && w_in_range) r_mem[r_addr] <= r_data;
            if (r_state == S_RD) r_ram_q <= r_mem[r_addr];
        end
    end
endmodule

// File: tb/tb_delay_mem_arbiter.sv
// tb_delay_mem_arbiter: table-driven transactions, hand sequences for multi-cycle
// corners, and randomized traffic against a transaction-level model.
module tb_delay_mem_arbiter;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int DS = 3000;
    localparam int AW = 12;

    typedef struct {
        logic          wr;
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
        logic          inv;
    } txn_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b1;
    logic [NP-1:0]    wr_req = '0;
    logic [NP-1:0]    rd_req = '0;
    logic [NP*AW-1:0] wr_addr = '0;
    logic [NP*DW-1:0] wr_data = '0;
    logic [NP*AW-1:0] rd_addr = '0;
    logic [NP-1:0]    wr_ack;
    logic [NP-1:0]    rd_valid;
    logic [DW-1:0]    rd_data;
    logic [1:0]       grant_port;
    logic             busy;
    logic             invalid;

    int vectors = 0;
    int miscompares = 0;

    delay_mem_arbiter #(.data_width(DW), .n_ports(NP), .memory_size(DS)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .wr_ack(wr_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .grant_port(grant_port), .busy(busy), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic chk_cyc(input string name, input logic [NP-1:0] e_ack, input logic [NP-1:0] e_val,
                           input logic e_inv, input logic e_busy);
        chk(name, {wr_ack, rd_valid, invalid, busy}, {e_ack, e_val, e_inv, e_busy});
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
        wr_req[p] = 1'b1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
        rd_req[p] = 1'b1;
    endtask

    // Caller is at the negedge of an IDLE cycle with no requests pending.
    task automatic do_txn(input txn_t t);
        int lat;
        logic [NP-1:0] pulse;
        lat = t.wr ? 2 : 3;
        if (t.wr) set_wr(t.port, t.addr, t.data);
        else set_rd(t.port, t.addr);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            pulse = (k == lat) ? NP'(1) << t.port : '0;
            chk_cyc("txn", t.wr ? pulse : '0, t.wr ? '0 : pulse, k == lat && t.inv, k <= lat);
            if (k == lat) begin
                chk("txn_grant", 64'(grant_port), 64'(t.port));
                if (!t.wr) chk("txn_rdata", 64'(rd_data), 64'(t.exp));
                if (t.wr) wr_req[t.port] = 1'b0;
                else rd_req[t.port] = 1'b0;
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int s;
        s = $urandom_range(0, 9);
        return s <= 5 ? AW'($urandom_range(0, 7)) : s == 6 ? AW'(DS - 1) : s == 7 ? AW'(DS) :
               s == 8 ? AW'(4095) : AW'($urandom);
    endfunction

    txn_t tbl[10];

    // Transaction-level model state for the randomized phase
    logic [DW-1:0] mm [int];
    int            cyc, next_idle, ptr;
    logic          have_ev, ev_wr, ev_inv, ev_known;
    int            ev_cyc, ev_port;
    logic [DW-1:0] ev_data;

    initial begin
        tbl[0] = '{1'b1, 0, 12'd5,    16'h1234, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 0, 12'd5,    16'h0000, 16'h1234, 1'b0};
        tbl[2] = '{1'b1, 3, 12'd2999, 16'hA5A5, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 3, 12'd2999, 16'h0000, 16'hA5A5, 1'b0};
        tbl[4] = '{1'b1, 1, 12'd3000, 16'hFFFF, 16'h0000, 1'b1};
        tbl[5] = '{1'b0, 1, 12'd3000, 16'h0000, 16'h0000, 1'b1};
        tbl[6] = '{1'b0, 2, 12'd4095, 16'h0000, 16'h0000, 1'b1};
        tbl[7] = '{1'b1, 1, 12'd0,    16'h0F0F, 16'h0000, 1'b0};
        tbl[8] = '{1'b0, 2, 12'd0,    16'h0000, 16'h0F0F, 1'b0};
        tbl[9] = '{1'b0, 0, 12'd2999, 16'h0000, 16'hA5A5, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outs", {wr_ack, rd_valid, rd_data, grant_port, busy, invalid}, '0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) do_txn(tbl[i]);

        // Same port, write and read to one address: write first, read sees new data
        set_wr(2, 12'd9, 16'hBEEF);
        set_rd(2, 12'd9);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk_cyc("wr_then_rd", k == 2 ? 4'b0100 : 4'b0, k == 6 ? 4'b0100 : 4'b0, 1'b0,
                    (k >= 1 && k <= 2) || (k >= 4 && k <= 6));
            if (k == 2) wr_req[2] = 1'b0;
            if (k == 6) begin
                chk("wr_then_rd_data", 64'(rd_data), 64'hBEEF);
                rd_req[2] = 1'b0;
            end
        end

        // Reset during RD_WAIT aborts the read; p0 then wins; RAM keeps addr 5
        set_rd(1, 12'd5);
        repeat (2) @(negedge clk);
        chk_cyc("pre_abort", 4'b0, 4'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        set_wr(0, 12'd20, 16'h5555);
        #1;
        chk_cyc("abort", 4'b0, 4'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_cyc("abort_hold", 4'b0, 4'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk_cyc("post_abort", k == 2 ? 4'b0001 : 4'b0, k == 6 ? 4'b0010 : 4'b0, 1'b0,
                    (k >= 1 && k <= 2) || (k >= 4 && k <= 6));
            if (k == 2) wr_req[0] = 1'b0;
            if (k == 6) begin
                chk("post_abort_data", 64'(rd_data), 64'h1234);
                rd_req[1] = 1'b0;
            end
        end

        // enable=0 freezes the FSM mid-write and stretches the ack pulse
        set_wr(3, 12'd30, 16'h7777);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk_cyc("enable_hold", (k >= 5 && k <= 7) ? 4'b1000 : 4'b0, 4'b0, 1'b0, k <= 7);
            if (k == 1 || k == 5) enable = 1'b0;
            if (k == 4 || k == 7) enable = 1'b1;
            if (k == 5) wr_req[3] = 1'b0;
        end
        do_txn('{1'b0, 3, 12'd30, 16'h0000, 16'h7777, 1'b0});

        // All ports hold wr_req from reset: acks p0,p1,p2,p3,p0 every 3 cycles
        reset_n = 1'b0;
        for (int p = 0; p < NP; p++) set_wr(p, AW'(100 + p), DW'(p));
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk_cyc("rr_fair", (k % 3 == 2) ? NP'(1) << ((k / 3) % NP) : '0, 4'b0, 1'b0, k % 3 != 0);
            if (k == 14) wr_req = '0;
        end
        @(negedge clk);

        // Randomized traffic; requesters hold until served
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        next_idle = 0;
        ptr = NP - 1;
        have_ev = 1'b0;
        repeat (1500) begin
            if (have_ev && ev_cyc == cyc) begin
                chk_cyc("rand", ev_wr ? NP'(1) << ev_port : '0, ev_wr ? '0 : NP'(1) << ev_port,
                        ev_inv, cyc != next_idle);
                chk("rand_grant", 64'(grant_port), 64'(ev_port));
                if (!ev_wr && ev_known) chk("rand_rdata", 64'(rd_data), 64'(ev_data));
                if (ev_wr) wr_req[ev_port] = 1'b0;
                else rd_req[ev_port] = 1'b0;
                have_ev = 1'b0;
            end else begin
                chk_cyc("rand", '0, '0, 1'b0, cyc != next_idle);
            end
            for (int p = 0; p < NP; p++) begin
                if (!wr_req[p] && $urandom_range(0, 5) == 0) set_wr(p, rand_addr(), DW'($urandom));
                if (!rd_req[p] && $urandom_range(0, 5) == 0) set_rd(p, rand_addr());
            end
            if (cyc == next_idle) begin
                next_idle = cyc + 1;
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (ptr + k) % NP;
                    if (!have_ev && (wr_req[p] || rd_req[p])) begin
                        int a;
                        have_ev = 1'b1;
                        ev_port = p;
                        ev_wr = wr_req[p];
                        a = ev_wr ? int'(wr_addr[p*AW +: AW]) : int'(rd_addr[p*AW +: AW]);
                        ev_inv = a >= DS;
                        ev_cyc = cyc + (ev_wr ? 2 : 3);
                        next_idle = cyc + (ev_wr ? 3 : 4);
                        ptr = p;
                        if (ev_wr) begin
                            if (!ev_inv) mm[a] = wr_data[p*DW +: DW];
                        end else begin
                            ev_known = ev_inv || mm.exists(a);
                            ev_data = ev_inv ? '0 : mm.exists(a) ? mm[a] : '0;
                        end
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
